// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU slice.
// Operation codes and handshake FSM states.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD,
        OP_SUB,
        OP_AND,
        OP_XOR,
        OP_SHL,
        OP_SHR,
        OP_MUL,
        OP_DIV
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_DONE
    } state_e;

endpackage

// File: rtl/alu_iter_unit.sv
// Shared shift-add multiply / restoring divide datapath.
// lo/hi present the post-step values so the caller can latch them on done.
module alu_iter_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             step,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    localparam logic [WIDTH-1:0] CNT_LAST = WIDTH[WIDTH-1:0] - 1'b1;

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             div_q, div_d;

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    always_comb begin
        acc_d  = acc_q;
        lo_d   = lo_q;
        opnd_d = opnd_q;
        cnt_d  = cnt_q;
        div_d  = div_q;
        sum    = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        rem_sh = {acc_q, lo_q[WIDTH-1]};
        diff   = rem_sh - {1'b0, opnd_q};
        if (start) begin
            acc_d  = '0;
            lo_d   = a;
            opnd_d = b;
            cnt_d  = '0;
            div_d  = is_div;
        end else if (step) begin
            cnt_d = cnt_q + 1'b1;
            if (div_q) begin
                // A clear borrow bit means the trial subtraction fits.
                if (!diff[WIDTH]) begin
                    acc_d = diff[WIDTH-1:0];
                    lo_d  = {lo_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = rem_sh[WIDTH-1:0];
                    lo_d  = {lo_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                {acc_d, lo_d} = {sum, lo_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            acc_q  <= '0;
            lo_q   <= '0;
            opnd_q <= '0;
            cnt_q  <= '0;
            div_q  <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            lo_q   <= lo_d;
            opnd_q <= opnd_d;
            cnt_q  <= cnt_d;
            div_q  <= div_d;
        end
    end

    assign done = step && (cnt_q == CNT_LAST);
    assign lo   = lo_d;
    assign hi   = acc_d;

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU with valid/ready handshakes on both sides.
// Single-cycle ops resolve in IDLE; MUL/DIV run in alu_iter_unit.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  op_e              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] r,
    output logic             carry,
    output logic             zero,
    output logic             dbz
);

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             dbz_q, dbz_d;

    logic             it_start;
    logic             it_step;
    logic             it_done;
    logic [WIDTH-1:0] it_lo;
    logic [WIDTH-1:0] it_hi;
    logic [WIDTH:0]   add_res;

    alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
        .clk    (clk),
        .reset  (reset),
        .start  (it_start),
        .is_div (op == OP_DIV),
        .a      (a),
        .b      (b),
        .step   (it_step),
        .done   (it_done),
        .lo     (it_lo),
        .hi     (it_hi)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        y_d      = y_q;
        r_d      = r_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        dbz_d    = dbz_q;
        it_start = 1'b0;
        it_step  = 1'b0;
        add_res  = {1'b0, a} + {1'b0, b};
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d    = op;
                    r_d     = '0;
                    carry_d = 1'b0;
                    dbz_d   = 1'b0;
                    state_d = S_DONE;
                    unique case (op)
                        OP_ADD: {carry_d, y_d} = add_res;
                        OP_SUB: begin
                            y_d     = a - b;
                            carry_d = (a < b);
                        end
                        OP_AND: y_d = a & b;
                        OP_XOR: y_d = a ^ b;
                        OP_SHL: y_d = a << b[SHW-1:0];
                        OP_SHR: y_d = a >> b[SHW-1:0];
                        OP_MUL, OP_DIV: begin
                            if (op == OP_DIV && b == '0) begin
                                y_d   = '1;
                                r_d   = a;
                                dbz_d = 1'b1;
                            end else begin
                                it_start = 1'b1;
                                state_d  = S_ITER;
                            end
                        end
                    endcase
                    zero_d = (y_d == '0);
                end
            end
            S_ITER: begin
                it_step = 1'b1;
                if (it_done) begin
                    y_d     = it_lo;
                    zero_d  = (it_lo == '0);
                    state_d = S_DONE;
                    if (op_q == OP_DIV) begin
                        r_d     = it_hi;
                        carry_d = 1'b0;
                    end else begin
                        r_d     = '0;
                        carry_d = |it_hi;
                    end
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            op_q    <= OP_ADD;
            y_q     <= '0;
            r_q     <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            y_q     <= y_d;
            r_q     <= r_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            dbz_q   <= dbz_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign y         = y_q;
    assign r         = r_q;
    assign carry     = carry_q;
    assign zero      = zero_q;
    assign dbz       = dbz_q;

endmodule
